// File: rtl/uart_wb.sv
// uart_wb: bus-attached 8N1 UART with a TX FIFO + serializer and a
// single-byte RX buffer + deserializer.
//
// Optional feature macro: UART_RX_EN
//   defined   -> receiver, rx_valid, RXOVR and the IRQ_EN bit1 path exist
//   undefined -> rx is ignored, DATA reads 0, STATUS bits 2/3 read 0
//
// Ports:
//   clk          system clock
//   rst_i        synchronous active-high reset
//   adr_i[3:0]   byte address, register index in adr_i[3:2]
//                (0 DATA, 1 STATUS, 2 DIV, 3 IRQ_EN)
//   dat_i[31:0]  write data
//   sel_i[3:0]   byte lanes (lane 0 for DATA/IRQ_EN, lanes 1:0 for DIV)
//   we_i         1 = write, 0 = read
//   stb_i        access request, held until ack_o
//   ack_o        one-cycle acknowledge
//   dat_o[31:0]  read data, valid while ack_o = 1
//   tx           serial out, idle high
//   rx           serial in, asynchronous
//   irq          level interrupt, registered
`timescale 1ns/1ps
module uart_wb #(
    parameter int FIFO_AW     = 4,
    parameter int DEFAULT_DIV = 217
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [15:0] DEFAULT_DIV_C = 16'(DEFAULT_DIV);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    // ---------------- bus decode ----------------
    logic        ack_q, irq_q, tx_q, txovf_q;
    logic [31:0] dat_q, rdata_s;
    logic [15:0] div_q, eff_div_s;
    logic [1:0]  irq_en_q;
    logic        access_s, data_wr_s, data_rd_s, status_rd_s, div_wr_s, irqen_wr_s;
    logic        rx_valid_s, rxovr_s;
    logic [7:0]  rx_byte_s;

    assign access_s    = stb_i & ~ack_q;
    assign data_wr_s   = access_s &  we_i & (adr_i[3:2] == 2'd0) & sel_i[0];
    assign data_rd_s   = access_s & ~we_i & (adr_i[3:2] == 2'd0);
    assign status_rd_s = access_s & ~we_i & (adr_i[3:2] == 2'd1);
    assign div_wr_s    = access_s &  we_i & (adr_i[3:2] == 2'd2);
    assign irqen_wr_s  = access_s &  we_i & (adr_i[3:2] == 2'd3) & sel_i[0];
    assign eff_div_s   = (div_q < 16'd2) ? 16'd2 : div_q;

    logic unused_s;
    assign unused_s = ^{dat_i[31:16], sel_i[3:2], adr_i[1:0]};

    // ---------------- TX FIFO ----------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   level_q;
    logic               tx_full_s, tx_empty_s, push_s, pop_s, txovf_set_s;

    assign tx_full_s   = (level_q == DEPTH_C);
    assign tx_empty_s  = (level_q == '0);
    // A push while full still fits when the serializer pops in the same cycle.
    assign push_s      = data_wr_s & (~tx_full_s | pop_s);
    assign txovf_set_s = data_wr_s & tx_full_s & ~pop_s;

    // FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= dat_i[7:0];
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_s) wptr_q <= wptr_q + 1'b1;
            if (pop_s)  rptr_q <= rptr_q + 1'b1;
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_end_s, tx_line_s, tx_idle_s;

    assign tx_end_s  = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_idle_s = tx_empty_s & (tx_state_q == ST_IDLE);

    // TX next state: one divisor per bit, back-to-back frames from STOP
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        pop_s      = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty_s) begin
                    pop_s      = 1'b1;
                    tx_sh_d    = mem_q[rptr_q];
                    tx_div_d   = eff_div_s;
                    tx_cnt_d   = 16'd0;
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_end_s) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_end_s) begin
                    tx_cnt_d = 16'd0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_end_s) begin
                    tx_cnt_d = 16'd0;
                    if (!tx_empty_s) begin
                        pop_s      = 1'b1;
                        tx_sh_d    = mem_q[rptr_q];
                        tx_div_d   = eff_div_s;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Line level for the current state; registered into tx_q
    always_comb begin
        case (tx_state_q)
            ST_START: tx_line_s = 1'b0;
            ST_DATA:  tx_line_s = tx_sh_q[0];
            default:  tx_line_s = 1'b1;
        endcase
    end

    // TX state registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_div_q   <= 16'd2;
            tx_bit_q   <= 3'd0;
            tx_sh_q    <= 8'd0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_line_s;
        end
    end

`ifdef UART_RX_EN
    // ---------------- RX deserializer ----------------
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_valid_q, rxovr_q, rx_store_s;

    assign rx_valid_s = rx_valid_q;
    assign rxovr_s    = rxovr_q;
    assign rx_byte_s  = rx_byte_q;

    // RX next state: start bit checked at div/2, then one sample per div
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_store_s = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_s2_q && rx_prev_q) begin
                    rx_div_d   = eff_div_s;
                    rx_cnt_d   = 16'd0;
                    rx_state_d = ST_START;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                    rx_cnt_d = 16'd0;
                    rx_bit_d = 3'd0;
                    // A start bit that is high again by mid-bit was a glitch
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d = 16'd0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_store_s = rx_s2_q;
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX synchronizer, state and receive buffer
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_div_q   <= 16'd2;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_byte_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rxovr_q    <= 1'b0;
        end else begin
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_store_s ? rx_sh_q : rx_byte_q;
            // Store wins over a same-cycle DATA read; that read already saw the old byte
            rx_valid_q <= rx_store_s | (rx_valid_q & ~data_rd_s);
            rxovr_q    <= (rxovr_q & ~status_rd_s) | (rx_store_s & rx_valid_q & ~data_rd_s);
        end
    end
`else
    logic unused_rx_s;
    assign unused_rx_s = rx;
    assign rx_valid_s  = 1'b0;
    assign rxovr_s     = 1'b0;
    assign rx_byte_s   = 8'd0;
`endif

    // ---------------- register file ----------------
    // Read mux for the addressed register
    always_comb begin
        rdata_s = 32'd0;
        case (adr_i[3:2])
            2'd0: rdata_s[8:0] = {rx_valid_s, rx_byte_s};
            2'd1: begin
                rdata_s[0]               = tx_full_s;
                rdata_s[1]               = tx_idle_s;
                rdata_s[2]               = rx_valid_s;
                rdata_s[3]               = rxovr_s;
                rdata_s[4]               = txovf_q;
                rdata_s[8 +: FIFO_AW+1]  = level_q;
            end
            2'd2:    rdata_s[15:0] = div_q;
            2'd3:    rdata_s[1:0]  = irq_en_q;
            default: rdata_s = 32'd0;
        endcase
    end

    // Bus handshake, control registers, sticky TXOVF and irq
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            div_q    <= DEFAULT_DIV_C;
            irq_en_q <= 2'd0;
            txovf_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= access_s;
            dat_q <= access_s ? rdata_s : dat_q;
            if (div_wr_s && sel_i[0]) div_q[7:0]  <= dat_i[7:0];
            if (div_wr_s && sel_i[1]) div_q[15:8] <= dat_i[15:8];
            if (irqen_wr_s) irq_en_q <= dat_i[1:0];
            // A flag set in the same cycle as the clearing STATUS read survives
            txovf_q <= (txovf_q & ~status_rd_s) | txovf_set_s;
            irq_q   <= (irq_en_q[0] & tx_idle_s) | (irq_en_q[1] & rx_valid_s);
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign tx    = tx_q;
    assign irq   = irq_q;
endmodule

// File: tb/tb_uart_wb.sv
`timescale 1ns/1ps
module tb_uart_wb;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  adr_i = 4'h0;
    logic [31:0] dat_i = 32'h0;
    logic [3:0]  sel_i = 4'h0;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic [31:0] dat_o;
    logic        tx;
    logic        rx = 1'b1;
    logic        irq;

    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_DIV = 4'h8, A_IRQ = 4'hC;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_wb dut (
        .clk(clk), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
        .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o),
        .tx(tx), .rx(rx), .irq(irq)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access; returns at the falling edge after the ack edge.
    task automatic wb(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata);
        logic got;
        @(negedge clk);
        stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk);
            #1;
            if (ack_o === 1'b1) got = 1'b1;
        end
        rdata = dat_o;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: observed no ack expected ack within 4 cycles");
        end
        @(negedge clk);
        stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        logic [31:0] unused_rd;
        wb(1'b1, adr, dat, 4'hF, unused_rd);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [31:0] exp);
        logic [31:0] rv;
        wb(1'b0, adr, 32'h0, 4'hF, rv);
        check(tag, rv, exp);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Check a TX frame at mid-bit; base is the cycle count of the DATA write ack edge.
    task automatic chk_frame(input string tag, input int base, input int div, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wait_cyc(base + 2 + div * i + div / 2);
            check(tag, {31'd0, tx}, {31'd0, fr[i]});
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = fr[i];
            repeat (div - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int p, n;
        logic [9:0] fr55;
        logic got;

        // ---------- reset ----------
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        rd_chk("rst_div", A_DIV, 32'd217);
        rd_chk("rst_irqen", A_IRQ, 32'd0);
        rd_chk("rst_status", A_STAT, 32'h2);
        rd_chk("rst_data", A_DATA, 32'h0);

        // ---------- DIV per-lane write ----------
        begin
            logic [31:0] unused_rd;
            wb(1'b1, A_DIV, 32'h0000_1234, 4'b0010, unused_rd);
        end
        rd_chk("div_lane1", A_DIV, 32'h0000_12D9);

        // ---------- 0x55 at DIV=4 ----------
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'h55);
        check("tx55_pre", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("tx55_ack1", {31'd0, tx}, 32'd1);
        fr55 = {1'b1, 8'h55, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("tx55_bit", {31'd0, tx}, {31'd0, fr55[b]});
            end
        end
        rd_chk("tx55_idle", A_STAT, 32'h2);

        // ---------- FIFO overflow while stalled mid-frame ----------
        wr(A_DIV, 32'd8);
        wr(A_DATA, 32'hC3);
        p = cyc;
        for (int i = 1; i <= 17; i++) wr(A_DATA, 32'h30 + i);
        rd_chk("ovf_status1", A_STAT, 32'h0000_1011);
        rd_chk("ovf_status2", A_STAT, 32'h0000_1001);
        for (int k = 1; k <= 16; k++) chk_frame("ovf_frame", p + 80 * k, 8, 8'(8'h30 + k));
        wait_cyc(p + 1 + 80 * 17 + 1);
        rd_chk("ovf_drained", A_STAT, 32'h2);

        // ---------- irq from tx_idle ----------
        wr(A_IRQ, 32'd3);
        check("irq_wr_edge", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_on", {31'd0, irq}, 32'd1);
        wr(A_DATA, 32'h0F);
        check("irq_push_edge", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_busy", {31'd0, irq}, 32'd0);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (irq === 1'b1) got = 1'b1;
        end
        check("irq_done", {31'd0, got}, 32'd1);
        wr(A_IRQ, 32'd0);

        // ---------- reset mid-frame ----------
        wr(A_DATA, 32'hA5);
        n = cyc;
        wr(A_DATA, 32'h5A);
        wait_cyc(n + 2 + 32 + 4);
        check("mid_bit3", {31'd0, tx}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_tx", {31'd0, tx}, 32'd1);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        check("mrst_ack", {31'd0, ack_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        rd_chk("mrst_status", A_STAT, 32'h2);
        rd_chk("mrst_div", A_DIV, 32'd217);
        rd_chk("mrst_irqen", A_IRQ, 32'd0);
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'h96);
        n = cyc;
        chk_frame("post_rst_frame", n, 4, 8'h96);

        // ---------- DIV below minimum acts as 2 ----------
        wait_cyc(n + 2 + 40 + 2);
        wr(A_DIV, 32'd0);
        wr(A_DATA, 32'h01);
        n = cyc;
        chk_frame("div0_frame", n, 2, 8'h01);
        wait_cyc(n + 2 + 20 + 2);
        rd_chk("div0_idle", A_STAT, 32'h2);

        // ---------- receiver ----------
        wr(A_DIV, 32'd8);
`ifdef UART_RX_EN
        rx_frame(8'hA3, 1'b1, 8);
        repeat (8) @(negedge clk);
        rd_chk("rx_status", A_STAT, 32'h6);
        rd_chk("rx_data", A_DATA, 32'h1A3);
        rd_chk("rx_cleared", A_STAT, 32'h2);
        rx_frame(8'h11, 1'b1, 8);
        rx_frame(8'h22, 1'b1, 8);
        repeat (8) @(negedge clk);
        rd_chk("rx_ovr_status", A_STAT, 32'hE);
        rd_chk("rx_ovr_clr", A_STAT, 32'h6);
        rd_chk("rx_ovr_data", A_DATA, 32'h122);
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        rd_chk("rx_glitch", A_STAT, 32'h2);
        rx_frame(8'h5C, 1'b0, 8);
        repeat (20) @(negedge clk);
        rd_chk("rx_frm_status", A_STAT, 32'h2);
        rd_chk("rx_frm_data", A_DATA, 32'h022);
        wr(A_IRQ, 32'd2);
        check("rx_irq_off", {31'd0, irq}, 32'd0);
        rx_frame(8'h7E, 1'b1, 8);
        repeat (8) @(negedge clk);
        check("rx_irq_on", {31'd0, irq}, 32'd1);
        rd_chk("rx_irq_data", A_DATA, 32'h17E);
        check("rx_irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("rx_irq_clr", {31'd0, irq}, 32'd0);
`else
        rx_frame(8'hA3, 1'b1, 8);
        repeat (8) @(negedge clk);
        rd_chk("norx_status", A_STAT, 32'h2);
        rd_chk("norx_data", A_DATA, 32'h0);
        wr(A_IRQ, 32'd2);
        @(negedge clk);
        check("norx_irq", {31'd0, irq}, 32'd0);
        rd_chk("norx_irqen", A_IRQ, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_wb.md
# uart_wb

Bus-attached 8N1 UART peripheral for the SoC, decoded at bank 8'h03 (stb_i gated by adr_o[31:24] == 8'h03, ack_o muxed into the CPU ack like the video bank). It provides a TX FIFO with a serializer and a single-byte RX buffer with a deserializer. Its level-sensitive irq drives the CPU irq input, which is currently tied low.

## Interface
- FIFO_AW, 4: TX FIFO address width; depth = 2**FIFO_AW entries.
- DEFAULT_DIV, 217: reset divisor, in clock cycles per bit (25 MHz / 115200).
- clk  in  1  system clock, 25 MHz.
- rst_i  in  1  reset, synchronous, active-high.
- adr_i  in  4  byte address; only adr_i[3:2] decoded.
- dat_i  in  32  write data.
- sel_i  in  4  byte lanes; register writes use sel_i[0] (DATA) or sel_i[1:0] (DIV).
- we_i  in  1  1 = write, 0 = read.
- stb_i  in  1  access request, held until ack_o.
- ack_o  out  1  one-cycle access acknowledge.
- dat_o  out  32  read data, valid while ack_o = 1.
- tx  out  1  serial out, idle high.
- rx  in  1  serial in, asynchronous.
- irq  out  1  interrupt request, level, registered.

## Operation
- Registers are selected by adr_i[3:2]. Unused read bits return 0.
- **0 DATA, write:**
  - Push dat_i[7:0] into the TX FIFO if sel_i[0] = 1.
  - If the FIFO is full, drop the byte and set TXOVF.
- **0 DATA, read:**
  - Returns {23'b0, rx_valid, rx_byte}.
  - Clears rx_valid.
- **1 STATUS, read:**
  - bit0 tx_full.
  - bit1 tx_idle (FIFO empty and serializer in IDLE).
  - bit2 rx_valid.
  - bit3 RXOVR (sticky).
  - bit4 TXOVF (sticky).
  - bits[12:8] FIFO level, 0..2**FIFO_AW.
  - Reading STATUS clears RXOVR and TXOVF. Writes are ignored.
- **2 DIV, read/write:**
  - 16-bit divisor, written with per-lane sel_i[1:0].
  - Effective divisor = max(DIV, 2).
  - Latched per frame, separately by TX and RX, at frame start.
- **3 IRQ_EN, read/write:**
  - bit0 enables the tx_idle interrupt; bit1 enables the rx_valid interrupt.
  - irq <= (en0 & tx_idle) | (en1 & rx_valid), registered one cycle.
- **TX FSM:** IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each of START, DATA and STOP lasts exactly one divisor of cycles.
  - In IDLE with the FIFO non-empty: pop, latch the byte and the divisor, go to START.
  - At the end of STOP with the FIFO non-empty, go directly to START. There is no idle gap.
- **RX FSM:** IDLE -> START -> DATA -> STOP -> IDLE.
  - rx passes through a 2-flop synchronizer; the FSM acts on the synchronized value.
  - A falling edge in IDLE latches the divisor.
  - Sample the start bit at div/2. If it is high, treat it as a glitch and return to IDLE.
  - Then sample each data bit and the stop bit every div cycles.
  - Stop bit = 1: store the byte and set rx_valid. If rx_valid was already 1, also set RXOVR; the new byte overwrites.
  - Stop bit = 0 (framing error): discard the byte, no flag.
- **Simultaneous events:**
  - A FIFO push on the same cycle as a TX pop is both performed; the level is unchanged. When full, that same push is accepted, not dropped.
  - An RX store on the same cycle as a DATA read: the read returns the old byte, then rx_valid = 1 with the new byte, and RXOVR is not set.
  - A STATUS read on the same cycle as a flag set: the flag remains set.
- **Reset:** takes effect at the next edge even mid-frame. The FIFO is emptied and both FSMs return to IDLE.

## Timing
- **Access:** on an edge with stb_i = 1 and ack_o = 0:
  - the access is performed;
  - ack_o <= 1 and dat_o is loaded;
  - at the next edge ack_o <= 0.
- Each access therefore takes 2 cycles. A held stb_i is re-acknowledged every other cycle.
- **TX latency:**
  - A DATA write acked at edge N makes the FIFO non-empty after N.
  - Pop occurs at N+1; tx goes low at N+2.
  - A frame is 10·div cycles.
- **RX latency:** rx_valid rises 2 (synchronizer) + div/2 + 9·div + 1 cycles after the rx falling edge.
- **Reset values:**
  - Outputs: ack_o = 0, dat_o = 0, tx = 1, irq = 0.
  - Registers: DIV = DEFAULT_DIV, IRQ_EN = 0.
  - Flags and FIFO level = 0; rx_valid = 0.

## Configuration
- UART_RX_EN defined: receiver, rx_valid, RXOVR and the IRQ_EN bit1 path are present.
- UART_RX_EN undefined:
  - rx is unused; no RX logic is generated.
  - DATA read returns 0.
  - STATUS bit2 and bit3 read 0.
  - IRQ_EN bit1 is writable but has no effect on irq.

## Test plan
- Write DATA 0x55 with DIV = 4 -> tx low 2 cycles after ack; bit sequence 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop); 4 cycles per bit; then tx_idle = 1.
- Write 17 bytes to DATA back-to-back with FIFO_AW = 4 while TX is stalled mid-frame -> 16 accepted, 17th dropped, TXOVF = 1; next STATUS read shows it, following read shows 0; all accepted bytes sent with no gaps.
- Drive rx with 0xA3 at DIV = 8 -> rx_valid = 1, DATA read returns 0x1A3, then STATUS bit2 = 0; a second frame before the read -> RXOVR = 1 and the newest byte is kept.
- 2-cycle low glitch on rx at DIV = 8 -> no byte stored; a frame with stop bit 0 -> discarded, rx_valid stays 0.
- IRQ_EN = 3 with the FIFO empty -> irq = 1 one cycle after the write; write DATA -> irq falls once tx_idle = 0; after receiving a byte, irq stays 1 until DATA is read.
- Assert rst_i in the middle of DATA bit 3 of a TX frame -> tx = 1, level = 0, DIV = 217, irq = 0 after one edge; a subsequent write transmits normally.
